imem_program_loader: RTL and testbench

Instruction-memory program loader for the single-cycle MIPS core: the writer that produces the OpCode/Funct-bearing instruction words the core's control decoder consumes. It accepts a byte stream (length header plus big-endian words) over a valid/ready handshake, assembles 32-bit instructions, optionally screens each opcode/funct against the set the core decodes, writes them to instruction memory, and holds the CPU while loading.

---
 rtl/imem_program_loader_if.sv | 31 +++
 rtl/imem_program_loader.sv | 222 ++++++++++++++++++++++
 tb/tb_imem_program_loader.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_program_loader_if.sv
// Byte-stream and instruction-memory write bus for imem_program_loader.
// The master side (host or bench) drives start and the byte stream. The slave
// side (the loader) drives the memory write port, the CPU hold and the status.
interface imem_program_loader_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [31:0]       imem_wdata;
   logic              cpu_hold;
   logic              done;
   logic              error;
   logic [1:0]        err_code;
   logic [ADDR_W-1:0] err_addr;

   modport master (
      output start, in_valid, in_data,
      input  in_ready, imem_we, imem_addr, imem_wdata,
      input  cpu_hold, done, error, err_code, err_addr
   );

   modport slave (
      input  start, in_valid, in_data,
      output in_ready, imem_we, imem_addr, imem_wdata,
      output cpu_hold, done, error, err_code, err_addr
   );
endinterface

// File: rtl/imem_program_loader.sv
// Instruction-memory program loader for the single-cycle MIPS core.
// Input stream: a 16-bit big-endian word count N, then N big-endian 32-bit
// instructions. Each assembled word is written to instruction memory, and the
// CPU is held until the load completes.
// Optional feature: define LOADER_OPCHECK_EN to screen every opcode/funct
// against the set the core decodes. An illegal word aborts the load with
// err_code 2'b10. When the macro is undefined, every word is written.
module imem_program_loader #(
   parameter int unsigned ADDR_W = 8
) (
   input  logic                  clk,
   input  logic                  reset,
   imem_program_loader_if.slave  bus
);

   localparam int unsigned CNT_W = ADDR_W + 1;
   localparam int unsigned LEN_W = 16;
   localparam logic [LEN_W:0] CAP_WORDS = 17'(1) << ADDR_W;

   localparam logic [1:0] ERR_NONE = 2'b00;
   localparam logic [1:0] ERR_LEN  = 2'b01;
   localparam logic [1:0] ERR_ILL  = 2'b10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_BYTE,
      S_WRITE,
      S_DONE,
      S_ERR
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [LEN_W-1:0]    r_len, w_len_nxt;
   logic [CNT_W-1:0]    r_cnt, w_cnt_nxt;
   logic [1:0]          r_bidx, w_bidx_nxt;
   logic [23:0]         r_word, w_word_nxt;
   logic                r_legal, w_legal_nxt;
   logic                r_in_ready, w_in_ready_nxt;
   logic                r_imem_we, w_imem_we_nxt;
   logic [ADDR_W-1:0]   r_imem_addr, w_imem_addr_nxt;
   logic [31:0]         r_imem_wdata, w_imem_wdata_nxt;
   logic                r_cpu_hold, w_cpu_hold_nxt;
   logic                r_done, w_done_nxt;
   logic                r_error, w_error_nxt;
   logic [1:0]          r_err_code, w_err_code_nxt;
   logic [ADDR_W-1:0]   r_err_addr, w_err_addr_nxt;

   logic                w_hs;
   logic [31:0]         w_assembled;
   logic [LEN_W-1:0]    w_new_len;
   logic                w_word_ok;

`ifdef LOADER_OPCHECK_EN
   // Opcode/funct combinations the core's control decoder implements.
   function automatic logic f_legal(input logic [5:0] op, input logic [5:0] fn);
      logic ok;
      if (op == 6'h00) begin
         ok = fn inside {6'h00, 6'h02, 6'h03, 6'h08, 6'h09,
                         [6'h20:6'h27], 6'h2a, 6'h2b};
      end else begin
         ok = op inside {6'h02, 6'h03, 6'h04, 6'h08, 6'h09, 6'h0a,
                         6'h0b, 6'h0c, 6'h0f, 6'h23, 6'h2b};
      end
      return ok;
   endfunction
`endif

   // Byte transfer, word assembly and legality of the word being completed.
   always_comb begin
      w_hs        = bus.in_valid && r_in_ready;
      w_assembled = {r_word, bus.in_data};
      w_new_len   = {r_len[15:8], bus.in_data};
`ifdef LOADER_OPCHECK_EN
      w_word_ok   = f_legal(w_assembled[31:26], w_assembled[5:0]);
`else
      w_word_ok   = 1'b1;
`endif
   end

   // Next-state and next-output logic.
   always_comb begin
      w_state_nxt      = r_state;
      w_len_nxt        = r_len;
      w_cnt_nxt        = r_cnt;
      w_bidx_nxt       = r_bidx;
      w_word_nxt       = r_word;
      w_legal_nxt      = r_legal;
      w_imem_we_nxt    = 1'b0;
      w_imem_addr_nxt  = r_imem_addr;
      w_imem_wdata_nxt = r_imem_wdata;
      w_done_nxt       = r_done;
      w_error_nxt      = r_error;
      w_err_code_nxt   = r_err_code;
      w_err_addr_nxt   = r_err_addr;

      case (r_state)
         S_IDLE, S_DONE, S_ERR: begin
            if (bus.start) begin
               w_state_nxt    = S_LEN_HI;
               w_len_nxt      = '0;
               w_cnt_nxt      = '0;
               w_bidx_nxt     = '0;
               w_word_nxt     = '0;
               w_done_nxt     = 1'b0;
               w_error_nxt    = 1'b0;
               w_err_code_nxt = ERR_NONE;
               w_err_addr_nxt = '0;
            end
         end
         S_LEN_HI: begin
            if (w_hs) begin
               w_len_nxt   = {bus.in_data, r_len[7:0]};
               w_state_nxt = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (w_hs) begin
               w_len_nxt = w_new_len;
               if (w_new_len == '0) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else if ({1'b0, w_new_len} > CAP_WORDS) begin
                  w_state_nxt    = S_ERR;
                  w_error_nxt    = 1'b1;
                  w_err_code_nxt = ERR_LEN;
               end else begin
                  w_state_nxt = S_BYTE;
               end
            end
         end
         S_BYTE: begin
            if (w_hs) begin
               w_word_nxt = w_assembled[23:0];
               w_bidx_nxt = r_bidx + 2'd1;
               if (r_bidx == 2'd3) begin
                  // Write strobe is registered here so it lines up with WRITE.
                  w_state_nxt = S_WRITE;
                  w_legal_nxt = w_word_ok;
                  if (w_word_ok) begin
                     w_imem_we_nxt    = 1'b1;
                     w_imem_addr_nxt  = r_cnt[ADDR_W-1:0];
                     w_imem_wdata_nxt = w_assembled;
                  end
               end
            end
         end
         S_WRITE: begin
            if (r_legal) begin
               w_cnt_nxt = r_cnt + CNT_W'(1);
               if ((17'(r_cnt) + 17'd1) == {1'b0, r_len}) begin
                  w_state_nxt = S_DONE;
                  w_done_nxt  = 1'b1;
               end else begin
                  w_state_nxt = S_BYTE;
               end
            end else begin
               w_state_nxt    = S_ERR;
               w_error_nxt    = 1'b1;
               w_err_code_nxt = ERR_ILL;
               w_err_addr_nxt = r_cnt[ADDR_W-1:0];
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_in_ready_nxt = (w_state_nxt == S_LEN_HI) || (w_state_nxt == S_LEN_LO) ||
                       (w_state_nxt == S_BYTE);
      w_cpu_hold_nxt = (w_state_nxt != S_DONE);
   end

   // State and registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= S_IDLE;
         r_len        <= '0;
         r_cnt        <= '0;
         r_bidx       <= '0;
         r_word       <= '0;
         r_legal      <= 1'b0;
         r_in_ready   <= 1'b0;
         r_imem_we    <= 1'b0;
         r_imem_addr  <= '0;
         r_imem_wdata <= '0;
         r_cpu_hold   <= 1'b1;
         r_done       <= 1'b0;
         r_error      <= 1'b0;
         r_err_code   <= ERR_NONE;
         r_err_addr   <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_len        <= w_len_nxt;
         r_cnt        <= w_cnt_nxt;
         r_bidx       <= w_bidx_nxt;
         r_word       <= w_word_nxt;
         r_legal      <= w_legal_nxt;
         r_in_ready   <= w_in_ready_nxt;
         r_imem_we    <= w_imem_we_nxt;
         r_imem_addr  <= w_imem_addr_nxt;
         r_imem_wdata <= w_imem_wdata_nxt;
         r_cpu_hold   <= w_cpu_hold_nxt;
         r_done       <= w_done_nxt;
         r_error      <= w_error_nxt;
         r_err_code   <= w_err_code_nxt;
         r_err_addr   <= w_err_addr_nxt;
      end
   end

   assign bus.in_ready   = r_in_ready;
   assign bus.imem_we    = r_imem_we;
   assign bus.imem_addr  = r_imem_addr;
   assign bus.imem_wdata = r_imem_wdata;
   assign bus.cpu_hold   = r_cpu_hold;
   assign bus.done       = r_done;
   assign bus.error      = r_error;
   assign bus.err_code   = r_err_code;
   assign bus.err_addr   = r_err_addr;

endmodule

// File: tb/tb_imem_program_loader.sv
// Bench for imem_program_loader. A stream-level model derives the expected
// writes and the final status from each byte stream. A negedge monitor checks
// every write and the status invariants against that model.
module tb_imem_program_loader;

   localparam int unsigned ADDR_W = 8;
   localparam int unsigned CAP    = 1 << ADDR_W;
`ifdef LOADER_OPCHECK_EN
   localparam bit OPCHECK = 1'b1;
`else
   localparam bit OPCHECK = 1'b0;
`endif

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   imem_program_loader_if #(.ADDR_W(ADDR_W)) bus ();

   imem_program_loader #(.ADDR_W(ADDR_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_pass   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   // Stream and model state.
   logic [7:0]        tx_q[$];
   logic [ADDR_W-1:0] exp_addr[$];
   logic [31:0]       exp_data[$];
   bit                exp_done, exp_err;
   logic [1:0]        exp_code;
   logic [ADDR_W-1:0] exp_eaddr;
   int                exp_lat;

   logic [31:0]       tb_mem [CAP];
   int                n_writes = 0;
   int                cyc = 0;
   int                last_hs_cyc = 0;
   int                rise_cyc = 0;
   logic [ADDR_W-1:0] last_we_addr = '0;
   logic              prev_stat = 1'b0;

   // Legality from bit masks: bit k set means opcode/funct k is decoded.
   function automatic bit legal_word(input logic [31:0] w);
      logic [63:0] fmask;
      logic [63:0] omask;
      fmask = 64'h0000_0CFF_0000_030D;
      omask = 64'h0000_0808_0000_9F1C;
      if (w[31:26] == 6'd0) return fmask[w[5:0]];
      return omask[w[31:26]];
   endfunction

   function automatic logic [31:0] rand_legal();
      logic [31:0] w;
      for (int k = 0; k < 2000; k++) begin
         w = $urandom;
         if (legal_word(w)) return w;
      end
      return 32'h2008_0005;
   endfunction

   task automatic push_hdr(input int n);
      logic [15:0] v;
      v = 16'(n);
      tx_q.push_back(v[15:8]);
      tx_q.push_back(v[7:0]);
   endtask

   task automatic push_word(input logic [31:0] w);
      tx_q.push_back(w[31:24]);
      tx_q.push_back(w[23:16]);
      tx_q.push_back(w[15:8]);
      tx_q.push_back(w[7:0]);
   endtask

   // Derive expected writes and outcome; trim the stream to what will be accepted.
   task automatic model_load();
      int n, keep;
      logic [31:0] w;
      n = {tx_q[0], tx_q[1]};
      exp_done = 1'b0; exp_err = 1'b0; exp_code = 2'b00; exp_eaddr = '0; exp_lat = 2;
      keep = 2;
      if (n == 0) begin
         exp_done = 1'b1; exp_lat = 1;
      end else if (n > CAP) begin
         exp_err = 1'b1; exp_code = 2'b01; exp_lat = 1;
      end else begin
         exp_done = 1'b1;
         for (int i = 0; i < n; i++) begin
            w = {tx_q[2+4*i], tx_q[3+4*i], tx_q[4+4*i], tx_q[5+4*i]};
            keep = 2 + 4*(i+1);
            if (OPCHECK && !legal_word(w)) begin
               exp_done = 1'b0; exp_err = 1'b1; exp_code = 2'b10;
               exp_eaddr = ADDR_W'(i);
               break;
            end
            exp_addr.push_back(ADDR_W'(i));
            exp_data.push_back(w);
         end
      end
      while (tx_q.size() > keep) void'(tx_q.pop_back());
   endtask

   // Cycle counter.
   initial forever begin
      @(posedge clk);
      cyc++;
   end

   // Monitor: every write against the model, plus status invariants.
   initial forever begin
      @(negedge clk);
      if (!reset) begin
         if (bus.in_valid && bus.in_ready) last_hs_cyc = cyc;
         if (bus.imem_we) begin
            if (exp_addr.size() == 0) begin
               chk("unexpected imem_we", 1'b1, 1'b0);
            end else begin
               chk("imem_addr", bus.imem_addr, exp_addr.pop_front());
               chk("imem_wdata", bus.imem_wdata, exp_data.pop_front());
            end
            chk("imem_we latency", cyc, last_hs_cyc + 1);
            tb_mem[bus.imem_addr] = bus.imem_wdata;
            last_we_addr = bus.imem_addr;
            n_writes++;
         end
         if ((bus.done || bus.error) && !prev_stat) rise_cyc = cyc;
         prev_stat = bus.done || bus.error;
         chk("cpu_hold vs done", bus.cpu_hold, !bus.done);
         if (bus.done || bus.error) chk("in_ready while stopped", bus.in_ready, 1'b0);
      end else begin
         prev_stat = 1'b0;
      end
   end

   task automatic pulse_start();
      bus.start = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
   endtask

   // gap < 0: random 0..3 idle cycles before each byte.
   task automatic drive_bytes(input int gap);
      int t, g;
      foreach (tx_q[i]) begin
         g = (gap < 0) ? int'($urandom_range(3, 0)) : gap;
         repeat (g) begin
            bus.in_data = 8'($urandom);
            @(posedge clk); #1;
         end
         bus.in_valid = 1'b1;
         bus.in_data  = tx_q[i];
         t = 0;
         while (!bus.in_ready) begin
            @(posedge clk); #1;
            t++;
            if (t > 50) begin
               chk("in_ready wait timeout", 1'b0, 1'b1);
               bus.in_valid = 1'b0;
               return;
            end
         end
         @(posedge clk); #1;
         bus.in_valid = 1'b0;
      end
   endtask

   task automatic run_load(input int gap, input bit mid_start);
      int t;
      model_load();
      pulse_start();
      chk("start clears done", bus.done, 1'b0);
      chk("start clears error", bus.error, 1'b0);
      chk("start clears err_code", bus.err_code, 2'b00);
      chk("in_ready after start", bus.in_ready, 1'b1);
      if (mid_start) begin
         fork
            drive_bytes(gap);
            begin
               repeat (8) @(posedge clk);
               #1;
               pulse_start();
            end
         join
      end else begin
         drive_bytes(gap);
      end
      t = 0;
      while (!(bus.done || bus.error) && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 200) chk("status wait timeout", 1'b0, 1'b1);
      repeat (2) @(posedge clk);
      #1;
      chk("done", bus.done, exp_done);
      chk("error", bus.error, exp_err);
      chk("err_code", bus.err_code, exp_code);
      chk("err_addr", bus.err_addr, exp_eaddr);
      chk("cpu_hold final", bus.cpu_hold, !exp_done);
      chk("in_ready final", bus.in_ready, 1'b0);
      chk("pending writes", exp_addr.size(), 0);
      chk("status latency", rise_cyc, last_hs_cyc + exp_lat);
      tx_q.delete();
   endtask

   initial begin
      int w0, nr;
      reset = 1'b1;
      bus.start = 1'b0; bus.in_valid = 1'b0; bus.in_data = 8'h00;
      repeat (3) @(posedge clk);
      #1;
      chk("rst in_ready", bus.in_ready, 1'b0);
      chk("rst imem_we", bus.imem_we, 1'b0);
      chk("rst imem_addr", bus.imem_addr, '0);
      chk("rst imem_wdata", bus.imem_wdata, 32'h0);
      chk("rst cpu_hold", bus.cpu_hold, 1'b1);
      chk("rst done", bus.done, 1'b0);
      chk("rst error", bus.error, 1'b0);
      chk("rst err_code", bus.err_code, 2'b00);
      chk("rst err_addr", bus.err_addr, '0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Two-word reference program, back to back.
      w0 = n_writes;
      push_hdr(2); push_word(32'h2008_0005); push_word(32'h0109_5020);
      run_load(0, 1'b0);
      chk("ref mem[0]", tb_mem[0], 32'h2008_0005);
      chk("ref mem[1]", tb_mem[1], 32'h0109_5020);
      chk("ref writes", n_writes - w0, 2);
      chk("ref cpu_hold", bus.cpu_hold, 1'b0);

      // Empty program, started from DONE.
      w0 = n_writes;
      push_hdr(0);
      run_load(1, 1'b0);
      chk("n0 writes", n_writes - w0, 0);
      chk("n0 done", bus.done, 1'b1);

      // Length overflow.
      w0 = n_writes;
      push_hdr(CAP + 1);
      run_load(0, 1'b0);
      chk("ovf err_code", bus.err_code, 2'b01);
      chk("ovf writes", n_writes - w0, 0);

      // Full memory, started from ERR.
      w0 = n_writes;
      push_hdr(CAP);
      for (int i = 0; i < CAP; i++) push_word(rand_legal());
      run_load(0, 1'b0);
      chk("full last addr", last_we_addr, 8'hFF);
      chk("full writes", n_writes - w0, CAP);

      // lw followed by an undecoded opcode.
      w0 = n_writes;
      push_hdr(2); push_word(32'h8C08_0000); push_word(32'hFC00_0000);
      run_load(0, 1'b0);
      chk("ill mem[0]", tb_mem[0], 32'h8C08_0000);
      chk("ill writes", n_writes - w0, OPCHECK ? 1 : 2);
      chk("ill err_code", bus.err_code, OPCHECK ? 2'b10 : 2'b00);
      chk("ill err_addr", bus.err_addr, OPCHECK ? 8'd1 : 8'd0);

      // Sparse valid: one byte per three cycles.
      w0 = n_writes;
      push_hdr(2); push_word(32'h2008_0005); push_word(32'h0109_5020);
      run_load(2, 1'b0);
      chk("sparse mem[1]", tb_mem[1], 32'h0109_5020);
      chk("sparse writes", n_writes - w0, 2);

      // Reset after two bytes of word 1.
      w0 = n_writes;
      push_hdr(2); push_word(32'h2008_0005); push_word(32'h0109_5020);
      model_load();
      void'(exp_addr.pop_back());
      void'(exp_data.pop_back());
      void'(tx_q.pop_back());
      void'(tx_q.pop_back());
      pulse_start();
      drive_bytes(0);
      reset = 1'b1;
      #1;
      chk("midrst cpu_hold", bus.cpu_hold, 1'b1);
      chk("midrst in_ready", bus.in_ready, 1'b0);
      chk("midrst imem_we", bus.imem_we, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      chk("midrst writes", n_writes - w0, 1);
      chk("midrst pending", exp_addr.size(), 0);
      chk("midrst idle ready", bus.in_ready, 1'b0);
      chk("midrst idle done", bus.done, 1'b0);
      tx_q.delete();

      // start pulsed mid-load is ignored.
      w0 = n_writes;
      push_hdr(3);
      for (int i = 0; i < 3; i++) push_word(rand_legal());
      run_load(0, 1'b1);
      chk("midstart writes", n_writes - w0, 3);

      // Randomized loads.
      for (int r = 0; r < 25; r++) begin
         nr = $urandom_range(6, 0);
         if (r % 9 == 8) nr = CAP + 1 + $urandom_range(100, 0);
         push_hdr(nr);
         if (nr <= 6) begin
            for (int i = 0; i < nr; i++) begin
               if ($urandom_range(3, 0) == 0) push_word($urandom);
               else push_word(rand_legal());
            end
         end
         run_load(-1, 1'b0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
